alu_issue_decoder: RTL and testbench
====================================

# alu_issue_decoder

Decode and issue stage that feeds the ALU. It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes OP (R-type) and OP-IMM (I-type) instructions into the ALU's 4-bit operation code, register indices and immediate. It forwards the result through a registered, back-pressurable output with one cycle of latency. It sits between instruction fetch and the operand-read/ALU stage, and it is the only producer of the ALU op code.

## Interface
- No parameters. Widths are fixed: XLEN = 32, register index = 5, op = 4.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  upstream has an instruction word.
- instr  input  32  RV32I instruction word.
- instr_ready  output  1  stage can accept; a transfer occurs when instr_valid && instr_ready at the clock edge.
- dec_valid  output  1  decoded bundle valid.
- dec_ready  input  1  downstream accepts; a transfer occurs when dec_valid && dec_ready.
- dec_op  output  4  ALU op code.
- dec_rs1, dec_rs2, dec_rd  output  5 each  register indices.
- dec_imm  output  32  immediate.
- dec_use_imm  output  1  1 selects dec_imm as ALU operand b; 0 selects rs2.
- dec_illegal  output  1  instruction is not a legal OP or OP-IMM encoding.
- illegal_count  output  16  number of illegal instructions accepted; saturates at 0xFFFF.

## Operation
- ALU op encoding (fixed):
  - ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100.
  - XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001.
  - Codes 1010–1111 are never emitted.
- OP, opcode 0110011, with funct7 in {0000000, 0100000}; dec_use_imm=0, dec_imm=0.
  - funct3=000: ADD when funct7[5]=0, SUB when funct7[5]=1.
  - funct3=001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - funct3=101: SRL when funct7[5]=0, SRA when funct7[5]=1.
  - funct3=110: OR. 111: AND.
  - funct7=0100000 is legal only with funct3 000 or 101. Any other funct7 (including 0000001, the M extension) is illegal.
- OP-IMM, opcode 0010011: dec_use_imm=1 and dec_rs2=0.
  - Same funct3 mapping as OP, except funct3=000 is always ADD (no immediate SUB).
  - Non-shift immediate is instr[31:20] sign-extended.
  - funct3=001 (SLLI) requires instr[31:25]=0000000.
  - funct3=101 requires instr[31:25] = 0000000 (SRLI) or 0100000 (SRAI).
  - Shift immediate is instr[24:20] zero-extended.
- Illegal bundle: any other opcode, or a funct7 violation.
  - dec_illegal=1, dec_op=0000, dec_use_imm=0, dec_imm=0; rs1, rs2 and rd are still extracted.
  - The bundle is forwarded downstream, not dropped.
  - illegal_count increments at the input-transfer edge.
- Buffering: a 2-entry elastic buffer made of the output register plus one skid register.
  - Bundles leave in acceptance order, with no loss and no duplication.

## Timing
- Latency: an instruction accepted at edge N is presented on dec_valid/dec_* after edge N, provided the output register is empty or draining.
- Throughput: one instruction per cycle while dec_ready=1.
- instr_ready = skid register empty. It is a registered signal and must not depend combinationally on dec_ready.
- Back-pressure:
  - If the output register holds a bundle, dec_ready=0, and an input transfer occurs, the decoded bundle is stored in the skid register.
  - instr_ready deasserts on the next cycle.
- Drain:
  - When the output transfers and the skid register is full, the skid bundle moves to the output register on the same edge.
  - instr_ready reasserts on the next cycle.
- Simultaneous input and output transfer with the skid register empty: the new bundle replaces the output register and dec_valid stays 1.
- dec_* outputs are stable while dec_valid=1 and dec_ready=0.
- Reset (asynchronous, including mid-stream):
  - dec_valid=0, all dec_* outputs=0, skid register empty, instr_ready=1, illegal_count=0.
  - In-flight bundles are discarded.
  - No transfer is recognised while rst_n=0.
- Saturation: illegal_count holds at 0xFFFF.

## Structure
- Package alu_pkg:
  - alu_op_e enum carrying the op codes above; the ALU uses the same enum.
  - OPC_OP and OPC_OP_IMM constants.
  - FUNCT7_BASE and FUNCT7_ALT constants.
  - Packed struct dec_bundle_t {op, rs1, rs2, rd, imm, use_imm, illegal}.
- Decode is a pure function of instr (alu_decode_fn in alu_pkg).
- One sub-module: skid_buffer, generic over the dec_bundle_t payload, implementing the 2-entry elastic buffer and the handshake.

## Test plan
- 0x402081B3 (sub x3,x1,x2), dec_ready=1 → next cycle: dec_op=0001, rs1=1, rs2=2, rd=3, use_imm=0, illegal=0.
- 0xFFF00293 (addi x5,x0,-1) → dec_op=0000, dec_imm=0xFFFFFFFF, use_imm=1, rd=5. Then 0x4033D313 (srai x6,x7,3) → dec_op=0111, dec_imm=0x00000003, rs1=7.
- 0x00000000 followed by 0x023100B3 (mul) → both bundles have illegal=1 and dec_op=0000; illegal_count=2.
- Stream 4 legal instructions with dec_ready held 0 for 3 cycles:
  - instr_ready drops one cycle after the 2nd accept.
  - All 4 bundles emerge in order, with outputs held stable during the stall.
- Assert rst_n=0 mid-stream with the skid register full → immediately dec_valid=0, instr_ready=1, illegal_count=0; the first instruction after release has 1-cycle latency.
- Force illegal_count to 0xFFFE and feed 3 illegal instructions → illegal_count=0xFFFF and stays there.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Package : alu_pkg
// Brief   : ALU op codes, RV32I OP/OP-IMM constants, decoded bundle type and
//           the pure decode function shared by the issue stage and the ALU.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } dec_bundle_t;

    // alt selects SUB / SRA where funct3 allows it
    function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_bundle_t alu_decode_fn(input logic [31:0] instr);
        dec_bundle_t d;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        bad;
        funct3    = instr[14:12];
        funct7    = instr[31:25];
        bad       = 1'b0;
        d.op      = ALU_ADD;
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.rd      = instr[11:7];
        d.imm     = '0;
        d.use_imm = 1'b0;
        d.illegal = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                bad  = !((funct7 == FUNCT7_BASE) ||
                         ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                d.op = funct3_to_op(funct3, funct7[5]);
            end
            OPC_OP_IMM: begin
                d.use_imm = 1'b1;
                d.rs2     = '0;
                d.imm     = {{20{instr[31]}}, instr[31:20]};
                d.op      = funct3_to_op(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001) begin
                    bad   = (funct7 != FUNCT7_BASE);
                    d.imm = {27'd0, instr[24:20]};
                end else if (funct3 == 3'b101) begin
                    bad   = !((funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT));
                    d.imm = {27'd0, instr[24:20]};
                end
            end
            default: bad = 1'b1;
        endcase
        // Illegal words still carry their raw register fields downstream
        if (bad) begin
            d.op      = ALU_ADD;
            d.rs2     = instr[24:20];
            d.imm     = '0;
            d.use_imm = 1'b0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buffer.sv
// ============================================================================
// Module : skid_buffer
// Brief  : 2-entry elastic buffer (output register + skid register) with a
//          valid/ready handshake; upstream ready depends only on local state.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_out_load;

    assign in_ready   = ~r_skid_valid;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign w_in_fire  = in_valid & ~r_skid_valid;
    // Output register may take new data when empty or being consumed this edge
    assign w_out_load = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_decoder.sv
// ============================================================================
// Module : alu_issue_decoder
// Brief  : Decodes RV32I OP/OP-IMM words into ALU bundles and issues them
//          through a back-pressurable elastic buffer; counts illegal words.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_decoder
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [3:0]  dec_op,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [4:0]  dec_rd,
    output logic [31:0] dec_imm,
    output logic        dec_use_imm,
    output logic        dec_illegal,
    output logic [15:0] illegal_count
);

    localparam int          C_BUNDLE_W = $bits(dec_bundle_t);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    dec_bundle_t            w_dec;
    dec_bundle_t            w_out;
    logic [C_BUNDLE_W-1:0]  w_out_bits;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic [15:0]            r_illegal_count;

    assign w_dec     = alu_decode_fn(instr);
    assign w_in_fire = instr_valid & w_in_ready;

    skid_buffer #(
        .WIDTH (C_BUNDLE_W)
    ) u_skid_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (instr_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_dec),
        .out_valid (dec_valid),
        .out_ready (dec_ready),
        .out_data  (w_out_bits)
    );

    assign w_out = dec_bundle_t'(w_out_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_count <= '0;
        end else if (w_in_fire && w_dec.illegal && (r_illegal_count != C_CNT_MAX)) begin
            r_illegal_count <= r_illegal_count + 16'd1;
        end
    end

    assign instr_ready   = w_in_ready;
    assign dec_op        = w_out.op;
    assign dec_rs1       = w_out.rs1;
    assign dec_rs2       = w_out.rs2;
    assign dec_rd        = w_out.rd;
    assign dec_imm       = w_out.imm;
    assign dec_use_imm   = w_out.use_imm;
    assign dec_illegal   = w_out.illegal;
    assign illegal_count = r_illegal_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_decoder.sv
// ============================================================================
// Module : tb_alu_issue_decoder
// Brief  : Scoreboard bench for alu_issue_decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_decoder;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_op;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic        dec_illegal;
    logic [15:0] illegal_count;

    int          n_checks;
    int          n_errors;
    dec_bundle_t exp_q[$];
    dec_bundle_t cur_exp;
    dec_bundle_t cur_obs;
    dec_bundle_t held;
    dec_bundle_t popped;
    bit          prev_stall;

    alu_issue_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_op        (dec_op),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_rd        (dec_rd),
        .dec_imm       (dec_imm),
        .dec_use_imm   (dec_use_imm),
        .dec_illegal   (dec_illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic dec_bundle_t mk(input alu_op_e op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rd,
                                       input logic [31:0] imm, input logic use_imm,
                                       input logic illegal);
        dec_bundle_t b;
        b.op      = op;
        b.rs1     = rs1;
        b.rs2     = rs2;
        b.rd      = rd;
        b.imm     = imm;
        b.use_imm = use_imm;
        b.illegal = illegal;
        return b;
    endfunction

    // Monitor: sample at negedge; a transfer seen here happens on the next posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            cur_obs = {dec_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_use_imm, dec_illegal};
            if (prev_stall)
                chk("stall_stable", 64'(cur_obs), 64'(held));
            if (dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("bundle", 64'(cur_obs), 64'(popped));
                end
            end
            prev_stall = dec_valid && !dec_ready;
            held       = cur_obs;
            if (instr_valid && instr_ready)
                exp_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [31:0] ins, input dec_bundle_t e);
        bit done;
        bit rdy;
        done        = 1'b0;
        instr_valid = 1'b1;
        instr       = ins;
        cur_exp     = e;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = instr_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        instr_valid = 1'b0;
        if (!done)
            chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && ((exp_q.size() != 0) || dec_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dec_ready   = 1'b1;
        cur_exp     = '0;
        n_checks    = 0;
        n_errors    = 0;
        prev_stall  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("rst_illegal_count", 64'(illegal_count), 64'd0);
        chk("rst_bundle", 64'({dec_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_use_imm, dec_illegal}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type SUB with one-cycle latency
        send(32'h402081B3, mk(ALU_SUB, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0));
        chk("latency_sub", 64'(dec_valid), 64'd1);

        // I-type arithmetic and shift immediates
        send(32'hFFF00293, mk(ALU_ADD, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b0));
        send(32'h4033D313, mk(ALU_SRA, 5'd7, 5'd0, 5'd6, 32'h00000003, 1'b1, 1'b0));

        // Illegal words are forwarded and counted
        send(32'h00000000, mk(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1));
        send(32'h023100B3, mk(ALU_ADD, 5'd2, 5'd3, 5'd1, 32'h0, 1'b0, 1'b1));
        chk("illegal_count_2", 64'(illegal_count), 64'd2);
        drain();

        // Back-pressure: 4 legal words with dec_ready low for 3 cycles
        dec_ready = 1'b0;
        fork
            begin
                send(32'h003100B3, mk(ALU_ADD, 5'd2, 5'd3, 5'd1, 32'h0, 1'b0, 1'b0));
                send(32'h0062F233, mk(ALU_AND, 5'd5, 5'd6, 5'd4, 32'h0, 1'b0, 1'b0));
                chk("ready_drop", 64'(instr_ready), 64'd0);
                send(32'hFFB42393, mk(ALU_SLT, 5'd8, 5'd0, 5'd7, 32'hFFFFFFFB, 1'b1, 1'b0));
                send(32'h7FF54493, mk(ALU_XOR, 5'd10, 5'd0, 5'd9, 32'h000007FF, 1'b1, 1'b0));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                dec_ready = 1'b1;
            end
        join
        drain();
        chk("ready_back", 64'(instr_ready), 64'd1);

        // Asynchronous reset with the skid register full
        dec_ready = 1'b0;
        send(32'h003100B3, mk(ALU_ADD, 5'd2, 5'd3, 5'd1, 32'h0, 1'b0, 1'b0));
        send(32'h7FF54493, mk(ALU_XOR, 5'd10, 5'd0, 5'd9, 32'h000007FF, 1'b1, 1'b0));
        chk("skid_full", 64'(instr_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_dec_valid", 64'(dec_valid), 64'd0);
        chk("midrst_instr_ready", 64'(instr_ready), 64'd1);
        chk("midrst_illegal_count", 64'(illegal_count), 64'd0);
        chk("midrst_dec_rd", 64'(dec_rd), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0062F233, mk(ALU_AND, 5'd5, 5'd6, 5'd4, 32'h0, 1'b0, 1'b0));
        chk("latency_after_rst", 64'(dec_valid), 64'd1);
        drain();

        // Counter saturation
        force dut.r_illegal_count = 16'hFFFE;
        #1;
        release dut.r_illegal_count;
        chk("cnt_preload", 64'(illegal_count), 64'hFFFE);
        send(32'hFFFFFFFF, mk(ALU_ADD, 5'd31, 5'd31, 5'd31, 32'h0, 1'b0, 1'b1));
        chk("cnt_reach_max", 64'(illegal_count), 64'hFFFF);
        send(32'h4020E0B3, mk(ALU_ADD, 5'd1, 5'd2, 5'd1, 32'h0, 1'b0, 1'b1));
        send(32'h40209093, mk(ALU_ADD, 5'd1, 5'd2, 5'd1, 32'h0, 1'b0, 1'b1));
        chk("cnt_saturated", 64'(illegal_count), 64'hFFFF);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
